// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
   localparam int DATA_W     = 32;
   localparam int BYTE_LANES = 4;
   localparam int CNT_W      = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 32 storage, lane-enabled sync write, sync read
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [BYTE_LANES-1:0] we,
   input  logic                  re,
   input  logic                  clr,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < BYTE_LANES; i++)
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
   end
   // Read register holds between loads; cleared for a misaligned ack
   always_ff @(posedge clk_i) begin
      if (rst_i || clr) rdata <= '0;
      else if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory for the MEM stage; DMEM_BYTE_MASK_EN adds be_i lane masking
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [DATA_W-1:0] wdata_i,
`ifdef DMEM_BYTE_MASK_EN
   input  logic [BYTE_LANES-1:0] be_i,
`endif
   output logic              stall_o,
   output logic              ack_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o
);
   localparam int AW = $clog2(DEPTH);
   state_e                state;
   logic [CNT_W-1:0]      cnt;
   logic                  we_q, mis_q;
   logic [AW-1:0]         idx_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [BYTE_LANES-1:0] be_q, lane_we;
   logic                  commit;
   logic                  unused_addr;
   assign unused_addr = ^addr_i[31:AW+2];
   // A commit coinciding with reset is dropped with the access
   assign commit  = state == BUSY && cnt == '0 && !rst_i;
   assign lane_we = (commit && we_q && !mis_q) ? be_q : '0;
   assign stall_o = (state == IDLE && req_i) || state == BUSY;
   assign ack_o   = state == RESP;
   assign err_o   = ack_o && mis_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (req_i) begin
               state   <= BUSY;
               cnt     <= CNT_W'(LATENCY - 1);
               we_q    <= we_i;
               idx_q   <= addr_i[AW+1:2];
               mis_q   <= |addr_i[1:0];
               wdata_q <= wdata_i;
`ifdef DMEM_BYTE_MASK_EN
               be_q    <= be_i;
`else
               be_q    <= '1;
`endif
            end
            BUSY: if (cnt == '0) state <= RESP;
                  else cnt <= cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (lane_we),
      .re    (commit && !we_q && !mis_q),
      .clr   (commit && mis_q),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (rdata_o)
   );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder latency, data, errors, wrap and reset
module tb_dmem_responder;
   logic        clk_i = 0, rst_i = 1, req_i = 0, we_i = 0;
   logic [31:0] addr_i = 0, wdata_i = 0;
   logic [3:0]  be_i = 4'hF;
   logic        stall_o, ack_o, err_o;
   logic [31:0] rdata_o;
   int          total = 0, bad = 0, cyc = 0;
   int          lat, acyc, acyc0, pulses;
   logic [31:0] rd;
   logic        er;
   logic [7:0]  st;

   dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i),
`ifdef DMEM_BYTE_MASK_EN
      .be_i(be_i),
`endif
      .stall_o(stall_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Caller is just after a rising edge; returns just after the edge that ends the ack cycle
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req_i = 1; we_i = w; addr_i = a; wdata_i = d; be_i = b;
      lat = -1; st = '0; rd = 'x; er = 'x; acyc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         st[i % 8] = stall_o;
         if (ack_o) begin lat = i; rd = rdata_o; er = err_o; acyc = cyc; end
         @(posedge clk_i); #1;
         if (lat >= 0) break;
      end
      req_i = 0;
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk_i);
      check({tag, "_stall"}, 32'(stall_o), 0);
      check({tag, "_ack"},   32'(ack_o),   0);
      check({tag, "_err"},   32'(err_o),   0);
      @(posedge clk_i); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1 rst_i = 0;
      @(negedge clk_i);
      check("rst_stall", 32'(stall_o), 0);
      check("rst_ack",   32'(ack_o),   0);
      check("rst_rdata", rdata_o,      0);
      check("rst_err",   32'(err_o),   0);
      @(posedge clk_i); #1;

      xfer(1, 32'h10, 32'hDEADBEEF, 4'hF);
      check("st10_lat",   32'(lat), 3);
      check("st10_stall", 32'(st[3:0]), 32'b0111);
      check("st10_err",   32'(er), 0);
      idle_check("after_st10");
      xfer(0, 32'h10, 0, 4'hF);
      check("ld10_lat",   32'(lat), 3);
      check("ld10_stall", 32'(st[3:0]), 32'b0111);
      check("ld10_data",  rd, 32'hDEADBEEF);
      idle_check("after_ld10");
      @(negedge clk_i);
      check("hold_rdata", rdata_o, 32'hDEADBEEF);
      @(posedge clk_i); #1;

      xfer(1, 32'h20, 32'h11111111, 4'hF);
      acyc0 = acyc;
      xfer(0, 32'h20, 0, 4'hF);
      check("b2b_data", rd, 32'h11111111);
      check("b2b_gap",  32'(acyc - acyc0), 4);

      xfer(0, 32'h13, 0, 4'hF);
      check("mis_ld_lat",  32'(lat), 3);
      check("mis_ld_err",  32'(er), 1);
      check("mis_ld_data", rd, 0);
      xfer(1, 32'h13, 32'h55555555, 4'hF);
      check("mis_st_err", 32'(er), 1);
      idle_check("after_mis");
      xfer(0, 32'h10, 0, 4'hF);
      check("mis_st_keep", rd, 32'hDEADBEEF);
      check("mis_st_noerr", 32'(er), 0);

      xfer(1, 32'h400, 32'hA5A5A5A5, 4'hF);
      xfer(0, 32'h0, 0, 4'hF);
      check("wrap_data", rd, 32'hA5A5A5A5);

      xfer(1, 32'h30, 32'h12345678, 4'hF);
      req_i = 1; we_i = 1; addr_i = 32'h30; wdata_i = 32'hCAFEF00D; be_i = 4'hF;
      @(posedge clk_i); #1;
      rst_i = 1; req_i = 0;
      @(posedge clk_i); #1;
      rst_i = 0;
      @(negedge clk_i);
      check("rst_mid_stall", 32'(stall_o), 0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (ack_o) pulses++;
         @(negedge clk_i);
      end
      check("rst_mid_noack", 32'(pulses), 0);
      @(posedge clk_i); #1;
      xfer(0, 32'h30, 0, 4'hF);
      check("rst_mid_keep", rd, 32'h12345678);

`ifdef DMEM_BYTE_MASK_EN
      xfer(1, 32'h0, 32'h0, 4'hF);
      xfer(1, 32'h0, 32'hAABBCCDD, 4'b0101);
      xfer(0, 32'h0, 0, 4'h0);
      check("be_data", rd, 32'h00BB00DD);
      xfer(1, 32'h0, 32'hFFFFFFFF, 4'h0);
      check("be0_ack", 32'(lat), 3);
      xfer(0, 32'h0, 0, 4'hF);
      check("be0_keep", rd, 32'h00BB00DD);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
